// File: rtl/mips_pipe_pkg.sv
// ---------------------------------------------------------------------------
// mips_pipe_pkg
// Shared definitions for the MIPS pipeline buffers: the canonical NOP
// encoding, payload widths, and the fetch-stage payload record that later
// pipeline buffers reuse.
// ---------------------------------------------------------------------------
package mips_pipe_pkg;

    localparam int INST_W   = 32;
    localparam int BUNDLE_W = 26;

    // ori $zero,$zero,0 -- architecturally a no-op
    localparam logic [INST_W-1:0] NOP_INSTR = 32'h3400_0000;

    typedef struct packed {
        logic [INST_W-1:0]   instruction;
        logic [BUNDLE_W-1:0] bundle;
        logic [INST_W-1:0]   pc_seq;
    } fetch_entry_t;

    // Payload presented downstream whenever nothing valid is held
    function automatic fetch_entry_t empty_entry();
        fetch_entry_t e;
        e.instruction = NOP_INSTR;
        e.bundle      = {BUNDLE_W{1'b0}};
        e.pc_seq      = {INST_W{1'b0}};
        return e;
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// ---------------------------------------------------------------------------
// pipe_entry_reg
// One pipeline payload register with load enable.
// Ports:
//   clk     - clock, rising edge
//   reset   - synchronous active-high reset (clears payload)
//   i_load  - capture i_d this cycle
//   i_d     - payload to capture
//   o_q     - stored payload
// ---------------------------------------------------------------------------
module pipe_entry_reg
    import mips_pipe_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  fetch_entry_t i_d,
    output fetch_entry_t o_q
);

    fetch_entry_t r_q;

    // Payload storage: cleared on reset, otherwise loaded on demand
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_decode_buffer.sv
// ---------------------------------------------------------------------------
// fetch_decode_buffer
// Two-entry elastic FIFO between fetch and decode. in_ready drives the fetch
// PC enable so decode backpressure stalls fetch without losing an
// instruction. flush squashes all held entries; decode sees the canonical NOP
// with zero bundle/PC whenever nothing valid is held.
//
// Optional feature macro: FDB_PERF_EN adds stall_cycles / bubble_cycles
// performance counters and their ports.
//
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   in_valid/in_ready - fetch-side handshake (in_ready from registered count)
//   instruction_in, bundle_in, pc_seq_in - fetched payload
//   out_valid/out_ready - decode-side handshake
//   instruction_out, bundle_out, pc_seq_out - head payload or NOP/zero
//   flush             - squash all entries and any same-cycle push
//   stall_cycles, bubble_cycles - perf counters (FDB_PERF_EN only)
// ---------------------------------------------------------------------------
module fetch_decode_buffer
    import mips_pipe_pkg::*;
#(
    parameter int INST_W   = 32,
    parameter int BUNDLE_W = 26
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INST_W-1:0]   instruction_in,
    input  logic [BUNDLE_W-1:0] bundle_in,
    input  logic [INST_W-1:0]   pc_seq_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INST_W-1:0]   instruction_out,
    output logic [BUNDLE_W-1:0] bundle_out,
    output logic [INST_W-1:0]   pc_seq_out,
    input  logic                flush
`ifdef FDB_PERF_EN
    ,
    output logic [31:0]         stall_cycles,
    output logic [31:0]         bubble_cycles
`endif
);

    logic [1:0]   r_count;
    logic [1:0]   w_count_next;
    logic         w_push;
    logic         w_pop;
    logic         w_head_load;
    logic         w_tail_load;
    fetch_entry_t w_in_entry;
    fetch_entry_t w_head_d;
    fetch_entry_t w_head;
    fetch_entry_t w_tail;
    fetch_entry_t w_out_entry;

    // Handshakes depend only on registered occupancy and reset, so neither
    // side sees a combinational path from the other side's ready/valid.
    assign in_ready  = (r_count != 2'd2) && !reset;
    assign out_valid = (r_count != 2'd0) && !reset;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign w_in_entry.instruction = instruction_in;
    assign w_in_entry.bundle      = bundle_in;
    assign w_in_entry.pc_seq      = pc_seq_in;

    // Next occupancy and entry-load decisions; flush overrides push and pop
    always_comb begin
        w_count_next = r_count;
        w_head_load  = 1'b0;
        w_tail_load  = 1'b0;
        w_head_d     = w_in_entry;
        if (flush) begin
            w_count_next = 2'd0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (w_push) begin
                        w_head_load  = 1'b1;
                        w_count_next = 2'd1;
                    end else begin
                        w_count_next = 2'd0;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        // head consumed and replaced in the same cycle
                        w_head_load  = 1'b1;
                        w_count_next = 2'd1;
                    end else if (w_push) begin
                        w_tail_load  = 1'b1;
                        w_count_next = 2'd2;
                    end else if (w_pop) begin
                        w_count_next = 2'd0;
                    end else begin
                        w_count_next = 2'd1;
                    end
                end
                2'd2: begin
                    // full: in_ready is low, so only a pop can happen
                    if (w_pop) begin
                        w_head_d     = w_tail;
                        w_head_load  = 1'b1;
                        w_count_next = 2'd1;
                    end else begin
                        w_count_next = 2'd2;
                    end
                end
                default: begin
                    w_count_next = 2'd0;
                end
            endcase
        end
    end

    // Occupancy register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 2'd0;
        end else begin
            r_count <= w_count_next;
        end
    end

    pipe_entry_reg u_head (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_head_load),
        .i_d    (w_head_d),
        .o_q    (w_head)
    );

    pipe_entry_reg u_tail (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_tail_load),
        .i_d    (w_in_entry),
        .o_q    (w_tail)
    );

    // Head payload when valid, canonical NOP/zero otherwise
    always_comb begin
        if (out_valid) begin
            w_out_entry = w_head;
        end else begin
            w_out_entry = empty_entry();
        end
    end

    assign instruction_out = w_out_entry.instruction;
    assign bundle_out      = w_out_entry.bundle;
    assign pc_seq_out      = w_out_entry.pc_seq;

`ifdef FDB_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_bubble_cycles;

    // Perf counters: wrap naturally, cleared only by reset (flush ignored)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles  <= 32'd0;
            r_bubble_cycles <= 32'd0;
        end else begin
            if (out_valid && !out_ready) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end else begin
                r_stall_cycles <= r_stall_cycles;
            end
            if (!out_valid) begin
                r_bubble_cycles <= r_bubble_cycles + 32'd1;
            end else begin
                r_bubble_cycles <= r_bubble_cycles;
            end
        end
    end

    assign stall_cycles  = r_stall_cycles;
    assign bubble_cycles = r_bubble_cycles;
`endif

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// ---------------------------------------------------------------------------
// tb_fetch_decode_buffer
// Scoreboard bench: the driver appends accepted instructions to an expected
// FIFO (a plain queue with capacity two); a separate monitor compares the
// DUT's handshakes and head payload against that queue every cycle and pops
// on each decode handshake.
// ---------------------------------------------------------------------------
module tb_fetch_decode_buffer;
    import mips_pipe_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction_in;
    logic [25:0] bundle_in;
    logic [31:0] pc_seq_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction_out;
    logic [25:0] bundle_out;
    logic [31:0] pc_seq_out;
    logic        flush;
`ifdef FDB_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] bubble_cycles;
`endif

    fetch_decode_buffer #(.INST_W(32), .BUNDLE_W(26)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .instruction_in  (instruction_in),
        .bundle_in       (bundle_in),
        .pc_seq_in       (pc_seq_in),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .instruction_out (instruction_out),
        .bundle_out      (bundle_out),
        .pc_seq_out      (pc_seq_out),
        .flush           (flush)
`ifdef FDB_PERF_EN
        ,
        .stall_cycles    (stall_cycles),
        .bubble_cycles   (bubble_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fetch_entry_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: 4 time units after each rising edge, before the driver
    // updates the model at the falling edge.
    always @(posedge clk) begin
        int          occ;
        logic        exp_ir;
        logic        exp_ov;
        fetch_entry_t e;
        #4;
        occ    = exp_q.size();
        exp_ir = !reset && (occ < 2);
        exp_ov = !reset && (occ > 0);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
        if (exp_ov) begin
            e = exp_q[0];
            chk("instruction_out", instruction_out, e.instruction);
            chk("bundle_out", {6'd0, bundle_out}, {6'd0, e.bundle});
            chk("pc_seq_out", pc_seq_out, e.pc_seq);
            if (out_ready && !flush) begin
                void'(exp_q.pop_front());
            end
        end else begin
            chk("nop_instruction", instruction_out, 32'h3400_0000);
            chk("nop_bundle", {6'd0, bundle_out}, 32'd0);
            chk("nop_pc", pc_seq_out, 32'd0);
        end
    end

    // One bus cycle: drive after the edge, then update the expected FIFO
    // at the falling edge from the occupancy seen when the cycle began.
    task automatic cyc(input logic iv, input logic [31:0] ins, input logic ordy,
                       input logic fl, input logic rst);
        int occ0;
        fetch_entry_t e;
        @(posedge clk);
        #1;
        occ0           = exp_q.size();
        in_valid       = iv;
        instruction_in = ins;
        bundle_in      = ins[25:0] ^ 26'h2AA_AAAA;
        pc_seq_in      = ins + 32'd4;
        out_ready      = ordy;
        flush          = fl;
        reset          = rst;
        @(negedge clk);
        if (rst || fl) begin
            exp_q.delete();
        end else if (iv && (occ0 < 2)) begin
            e.instruction = ins;
            e.bundle      = ins[25:0] ^ 26'h2AA_AAAA;
            e.pc_seq      = ins + 32'd4;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        reset          = 1'b1;
        in_valid       = 1'b0;
        instruction_in = 32'd0;
        bundle_in      = 26'd0;
        pc_seq_in      = 32'd0;
        out_ready      = 1'b0;
        flush          = 1'b0;

        // Reset, then idle
        repeat (3) cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        repeat (2) cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

        // Streaming with decode always ready
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h1000_0000 + 32'(i), 1'b1, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

        // Backpressure: two stored, third held at fetch, then released
        cyc(1'b1, 32'h8C22_0004, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h0022_1820, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h1000_0003, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h1000_0003, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h1000_0003, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h1000_0003, 1'b1, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

        // Full buffer, flush with a push in the same cycle
        cyc(1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hAAAA_0002, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hAAAA_0003, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        // First post-flush push right away
        cyc(1'b1, 32'hBBBB_0001, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

        // Count 1 with simultaneous push and pop
        cyc(1'b1, 32'hCCCC_0001, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hCCCC_0002, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

        // Mid-operation reset discards entries
        cyc(1'b1, 32'hDDDD_0001, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hDDDD_0002, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0, $urandom,
                ($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < 5)  ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < 1)  ? 1'b1 : 1'b0);
        end
        repeat (3) cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

`ifdef FDB_PERF_EN
        // Stall counter: valid head held for 5 cycles with decode not ready
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'hEEEE_0001, 1'b0, 1'b0, 1'b0);
        repeat (5) cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        chk("stall_cycles", stall_cycles, 32'd5);
        chk("bubble_cycles", bubble_cycles, 32'd1);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
